// File: rtl/alu_pkg.sv
// Shared opcode map, opcode legality check and sequencer state encoding.
// Pure declarations; no latency or flow control.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_INC = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_NEG = 4'b0100;
    localparam logic [3:0] OP_ABS = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_XOR = 4'b1010;

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } seq_state_t;

    // 0110 is a hole in the ALU decode; everything above XOR is unassigned.
    function automatic logic is_legal_op(logic [3:0] op);
        return (op != 4'b0110) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw async button -> 2-FF sync -> optional counter debounce (DEBOUNCE_EN) -> one-cycle rising-edge pulse.
// Latency: pulse 3 clk after a clean pin rise, 3+DEB_CYCLES clk with DEBOUNCE_EN.
// Backpressure: none; a held button yields exactly one pulse.
module button_conditioner #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse_o
);

    logic sync1_q, sync2_q;
    logic prev_q, prev_d;
    logic pulse_q, pulse_d;
    logic level;

    if (DEB_CYCLES < 1) begin : g_deb_cycles_check
        $error("DEB_CYCLES must be at least 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // The debounced level follows the synchroniser only after it has
    // disagreed for DEB_CYCLES samples in a row; any agreement restarts.
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        prev_d  = level;
        pulse_d = level & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Loads ALU operand A, operand B and opcode from switches on enter presses, then snapshots result and flags.
// Latency: result captured 1 clk after opcode commit; buttons add 3 clk (3+DEB_CYCLES with DEBOUNCE_EN).
// Backpressure: none; clear aborts from any state and wins over a simultaneous enter.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int N          = 6,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic         btn_enter,
    input  logic         btn_clear,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_out,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] res_out,
    output logic [3:0]   res_flags,
    output logic         res_valid,
    output logic         op_err,
    output logic [2:0]   state_o
);

    if (N < 4) begin : g_width_check
        $error("N must be at least 4 to carry the opcode");
    end

    logic enter_pls, clear_pls;

    button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_enter (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_enter),
        .pulse_o (enter_pls)
    );

    button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_in  (btn_clear),
        .pulse_o (clear_pls)
    );

    seq_state_t   state_q, state_d;
    logic [N-1:0] alu_a_q, alu_a_d;
    logic [N-1:0] alu_b_q, alu_b_d;
    logic [3:0]   alu_sel_q, alu_sel_d;
    logic [N-1:0] res_out_q, res_out_d;
    logic [3:0]   res_flags_q, res_flags_d;
    logic         res_valid_q, res_valid_d;
    logic         op_err_q, op_err_d;

    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_out_d   = res_out_q;
        res_flags_d = res_flags_q;
        res_valid_d = res_valid_q;
        op_err_d    = op_err_q;

        if (clear_pls) begin
            state_d     = S_LOAD_A;
            alu_a_d     = '0;
            alu_b_d     = '0;
            alu_sel_d   = '0;
            res_out_d   = '0;
            res_flags_d = '0;
            res_valid_d = 1'b0;
            op_err_d    = 1'b0;
        end else begin
            case (state_q)
                S_LOAD_A: if (enter_pls) begin
                    alu_a_d     = sw;
                    res_valid_d = 1'b0;
                    state_d     = S_LOAD_B;
                end
                S_LOAD_B: if (enter_pls) begin
                    alu_b_d = sw;
                    state_d = S_LOAD_OP;
                end
                S_LOAD_OP: if (enter_pls) begin
                    if (is_legal_op(sw[3:0])) begin
                        alu_sel_d = sw[3:0];
                        op_err_d  = 1'b0;
                        state_d   = S_EXEC;
                    end else begin
                        op_err_d  = 1'b1;
                    end
                end
                // alu_sel changed on entry, so the ALU output has settled here.
                S_EXEC: begin
                    res_out_d   = alu_out;
                    res_flags_d = alu_flags;
                    res_valid_d = 1'b1;
                    state_d     = S_SHOW;
                end
                S_SHOW: if (enter_pls) begin
                    state_d = S_LOAD_A;
                end
                default: state_d = S_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_out_q   <= '0;
            res_flags_q <= '0;
            res_valid_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_out_q   <= res_out_d;
            res_flags_q <= res_flags_d;
            res_valid_q <= res_valid_d;
            op_err_q    <= op_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_out   = res_out_q;
    assign res_flags = res_flags_q;
    assign res_valid = res_valid_q;
    assign op_err    = op_err_q;
    assign state_o   = state_q;

endmodule
